pipelined_csel_adder: RTL and testbench
=======================================

# pipelined_csel_adder

Parametrised, pipelined carry-select adder. A WIDTH-bit add splits into NUM_BLK = WIDTH/BLK_W slices, and one slice is resolved per clock. This gives one result per cycle at a clock rate set by a single BLK_W-bit slice rather than the full ripple. The block sits in the arithmetic datapath between operand registers and a downstream consumer, using a valid/ready handshake on both sides with full backpressure.

## Interface
- WIDTH, 32, operand/result width; must be a multiple of BLK_W, otherwise elaboration fails
- BLK_W, 8, slice width; NUM_BLK = WIDTH/BLK_W ≥ 1 is the pipeline depth
- clk  in  1  rising-edge clock, the only clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operand beat present
- in_ready  out  1  block can accept a beat this cycle
- a, b  in  WIDTH each  operands
- cin  in  1  carry in
- sub  in  1  subtract request; present only with CSEL_SUB_EN
- out_valid  out  1  result beat present
- out_ready  in  1  consumer accepts the result
- sum  out  WIDTH  result
- cout  out  1  carry out of the MSB
- ovf  out  1  signed overflow
- zero  out  1  sum == 0

## Operation
- Pipeline registers: stage 1..NUM_BLK. Each stage holds:
  - a valid bit
  - the running carry
  - resolved low sum bits
  - the still-unresolved high a/b bits
- Stage i (i ≥ 1) captures the result of slice i−1.
  - Two slice sums are precomputed, one with carry-in 0 and one with carry-in 1.
  - The incoming carry selects between them: cin for slice 0, the stage i−1 register carry otherwise.
  - The selected sum bits are appended to the resolved bits.
- Global advance: en = out_ready | ~out_valid.
  - When en=1, every stage loads from its predecessor, including the valid bit.
  - When en=0, all stages hold.
  - in_ready = en, combinational.
- A beat is accepted when in_valid & in_ready. If in_valid=0 while en=1, stage 1 loads valid=0 (a bubble).
- Output ports are driven directly from stage NUM_BLK.
- Flags:
  - cout is the carry out of slice NUM_BLK−1.
  - ovf = carry into bit WIDTH−1 XOR cout, captured in the last stage.
  - zero = ~|sum.
- Arithmetic is modulo 2^WIDTH. Operands are treated as unsigned for cout and two's-complement for ovf.

## Timing
- Reset: all valid bits 0. out_valid=0, sum=0, cout=0, ovf=0, zero=0. in_ready=1 immediately, because out_valid=0.
- Latency: a beat accepted at edge t appears on out_valid/sum after edge t+NUM_BLK−1, i.e. NUM_BLK register stages. With NUM_BLK=1, the result is visible the cycle after acceptance.
- Throughput: 1 beat/cycle while out_ready=1. Bubbles propagate unchanged.
- Stall: out_valid=1 & out_ready=0 freezes all stages, drops in_ready, and holds sum/flags stable. Inputs are ignored while in_ready=0.
- Simultaneous out handshake and new input: both occur in the same cycle, with no bubble inserted.
- Reset mid-operation: all in-flight beats are discarded with no partial outputs. The first accepted beat after reset release emerges NUM_BLK cycles later.
- out_valid never deasserts without a completed handshake.

## Configuration
- CSEL_SUB_EN defined:
  - The sub port exists.
  - On acceptance with sub=1, slice 0 uses an effective carry-in of 1, ignoring cin.
  - The b operand is inverted at entry, giving sum = a − b. cout=1 means no borrow.
  - sub is sampled only on acceptance; inversion is applied before stage 1.
- CSEL_SUB_EN undefined: no sub port, add only; the behaviour is otherwise identical.

## Structure
- Package csel_pkg:
  - default BLK_W constant
  - a flags struct (cout, ovf, zero)
  - a function computing NUM_BLK with a divisibility check
- Sub-module csel_slice: combinational BLK_W-bit carry-select slice.
  - Inputs: a_blk, b_blk, c_in.
  - Outputs: s, c_out, and c_msb, the carry into the slice MSB, used for ovf.
  - Instantiated NUM_BLK times in a generate loop.
- Top-level: stage registers, valid chain, handshake logic.

## Test plan
- WIDTH=32, BLK_W=8, a=0x0000_00FF, b=0x0000_0001, cin=0, single beat → 4 cycles later sum=0x0000_0100, cout=0, ovf=0, zero=0.
- a=0xFFFF_FFFF, b=0x0000_0001, cin=0 (full carry chain across all slices) → sum=0, cout=1, zero=1, ovf=0. Also a=0x7FFF_FFFF, b=1 → sum=0x8000_0000, ovf=1, cout=0.
- Back-to-back stream of 100 random beats with out_ready=1 → 100 results in order on consecutive cycles, all matching a+b+cin mod 2^32.
- Random out_ready (50%) with continuous in_valid → no beats lost or duplicated, sum stable while stalled, in_ready equals out_ready|~out_valid every cycle.
- Assert rst with 3 beats in flight → out_valid=0 and all outputs 0 asynchronously. After release, a new beat emerges alone 4 cycles after acceptance.
- With CSEL_SUB_EN, sub=1, a=5, b=7 → sum=0xFFFF_FFFE, cout=0. Then a=7, b=5 → sum=2, cout=1. Repeat with BLK_W=32 (NUM_BLK=1) → latency 1.

Source files
------------

// File: rtl/csel_pkg.sv
// Shared types and helpers for the pipelined carry-select adder:
// default slice width, result flag bundle and pipeline-depth calculation.
package csel_pkg;

  localparam int CSEL_BLK_W = 8;

  typedef struct packed {
    logic cout;
    logic ovf;
    logic zero;
  } csel_flags_t;

  // Returns 0 for an illegal width/slice combination so the top can refuse to elaborate.
  function automatic int csel_num_blk(input int width, input int blk_w);
    if (blk_w < 1 || width < blk_w || (width % blk_w) != 0) begin
      return 0;
    end
    return width / blk_w;
  endfunction

endpackage

// File: rtl/pipelined_csel_adder_if.sv
// Operand/result valid-ready bundle for pipelined_csel_adder.
// The sub request signal only exists when CSEL_SUB_EN is defined.
interface pipelined_csel_adder_if #(
  parameter int WIDTH = 32
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef CSEL_SUB_EN
  logic             sub;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             zero;

  modport master (
`ifdef CSEL_SUB_EN
    output sub,
`endif
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, zero
  );

  modport slave (
`ifdef CSEL_SUB_EN
    input  sub,
`endif
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, ovf, zero
  );

endinterface

// File: rtl/csel_slice.sv
// Combinational BLK_W-bit carry-select slice: both carry-in cases are
// precomputed and the late-arriving carry only drives the final mux.
module csel_slice
  import csel_pkg::*;
#(
  parameter int BLK_W = CSEL_BLK_W
) (
  input  logic [BLK_W-1:0] a_blk,
  input  logic [BLK_W-1:0] b_blk,
  input  logic             c_in,
  output logic [BLK_W-1:0] s,
  output logic             c_out,
  output logic             c_msb
);

  logic [BLK_W:0] sumC0;
  logic [BLK_W:0] sumC1;

  assign sumC0 = {1'b0, a_blk} + {1'b0, b_blk};
  assign sumC1 = {1'b0, a_blk} + {1'b0, b_blk} + (BLK_W + 1)'(1);

  assign {c_out, s} = c_in ? sumC1 : sumC0;

  // Carry into the MSB is recovered from the MSB sum bit and its operands.
  assign c_msb = s[BLK_W-1] ^ a_blk[BLK_W-1] ^ b_blk[BLK_W-1];

endmodule

// File: rtl/pipelined_csel_adder.sv
// Pipelined carry-select adder resolving one BLK_W slice per stage, with a
// global valid/ready stall. Define CSEL_SUB_EN to add the a - b mode.
module pipelined_csel_adder
  import csel_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int BLK_W = CSEL_BLK_W
) (
  input logic               clk,
  input logic               rst,
  pipelined_csel_adder_if.slave bus
);

  localparam int NUM_BLK = csel_num_blk(WIDTH, BLK_W);

  if (NUM_BLK == 0) begin : g_bad_width
    $error("pipelined_csel_adder: WIDTH must be a nonzero multiple of BLK_W");
  end

  logic             en;
  logic [WIDTH-1:0] bEntry;
  logic             cEntry;

  // Subtraction is folded into the operand before stage 1: invert b, force carry-in.
  always_comb begin
    en = bus.out_ready | ~bus.out_valid;
`ifdef CSEL_SUB_EN
    bEntry = bus.sub ? ~bus.b : bus.b;
    cEntry = bus.sub | bus.cin;
`else
    bEntry = bus.b;
    cEntry = bus.cin;
`endif
  end

  assign bus.in_ready = en;

  // word_q holds resolved sum bits at the top and still-unused a bits at the bottom;
  // each stage shifts one slice of a out and one slice of sum in.
  for (genvar k = 1; k <= NUM_BLK; k++) begin : g_stage
    localparam int REM   = WIDTH - k * BLK_W;
    localparam int SRC_W = REM + BLK_W;

    logic [WIDTH-1:0] srcWord;
    logic [SRC_W-1:0] srcB;
    logic             srcC;
    logic             srcV;
    logic [BLK_W-1:0] sliceSum;
    logic             cOut;
    logic             cMsb;
    logic [WIDTH-1:0] word_d;
    logic [WIDTH-1:0] word_q;
    logic             valid_d;
    logic             valid_q;

    if (k == 1) begin : g_src
      assign srcWord = bus.a;
      assign srcB    = bEntry;
      assign srcC    = cEntry;
      assign srcV    = bus.in_valid;
    end else begin : g_src
      assign srcWord = g_stage[k-1].word_q;
      assign srcB    = g_stage[k-1].g_rem.b_q;
      assign srcC    = g_stage[k-1].g_rem.carry_q;
      assign srcV    = g_stage[k-1].valid_q;
    end

    csel_slice #(
      .BLK_W (BLK_W)
    ) u_slice (
      .a_blk (srcWord[BLK_W-1:0]),
      .b_blk (srcB[BLK_W-1:0]),
      .c_in  (srcC),
      .s     (sliceSum),
      .c_out (cOut),
      .c_msb (cMsb)
    );

    assign word_d  = (srcWord >> BLK_W) | (WIDTH'(sliceSum) << (WIDTH - BLK_W));
    assign valid_d = srcV;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        valid_q <= 1'b0;
        word_q  <= '0;
      end else if (en) begin
        valid_q <= valid_d;
        word_q  <= word_d;
      end
    end

    if (REM > 0) begin : g_rem
      logic [REM-1:0] b_d;
      logic [REM-1:0] b_q;
      logic           carry_d;
      logic           carry_q;

      assign b_d     = srcB[SRC_W-1:BLK_W];
      assign carry_d = cOut;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          b_q     <= '0;
          carry_q <= 1'b0;
        end else if (en) begin
          b_q     <= b_d;
          carry_q <= carry_d;
        end
      end
    end else begin : g_last
      csel_flags_t flags_d;
      csel_flags_t flags_q;

      always_comb begin
        flags_d.cout = cOut;
        flags_d.ovf  = cMsb ^ cOut;
        flags_d.zero = ~|word_d;
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          flags_q <= '0;
        end else if (en) begin
          flags_q <= flags_d;
        end
      end

      assign bus.out_valid = valid_q;
      assign bus.sum       = word_q;
      assign bus.cout      = flags_q.cout;
      assign bus.ovf       = flags_q.ovf;
      assign bus.zero      = flags_q.zero;
    end
  end

endmodule

// File: tb/tb_pipelined_csel_adder.sv
// Directed self-checking bench for pipelined_csel_adder: reset, single beats,
// streaming, backpressure, mid-flight reset and (with CSEL_SUB_EN) subtraction.
module tb_pipelined_csel_adder;

  localparam int WIDTH    = 32;
  localparam int TB_BLK_W = 8;
  localparam int NB       = WIDTH / TB_BLK_W;
  localparam int NVEC     = 8;
  localparam int MAX_WAIT = 40;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic [31:0] s;
    logic        c;
    logic        o;
    logic        z;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   nChecks = 0;
  int   nFails  = 0;
  vec_t vecs [NVEC];

  pipelined_csel_adder_if #(.WIDTH(WIDTH)) bus ();

  pipelined_csel_adder #(
    .WIDTH (WIDTH),
    .BLK_W (TB_BLK_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic driveIdle();
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.cin       = 1'b0;
    bus.out_ready = 1'b1;
`ifdef CSEL_SUB_EN
    bus.sub       = 1'b0;
`endif
  endtask

  task automatic test_reset();
    rst = 1'b1;
    driveIdle();
    repeat (2) @(negedge clk);
    nChecks++;
    if ({bus.out_valid, bus.cout, bus.ovf, bus.zero, bus.in_ready} !== 5'b00001) begin
      nFails++;
      $display("[TB] FAIL reset_ctrl: got v/c/o/z/rdy=%b required 00001",
               {bus.out_valid, bus.cout, bus.ovf, bus.zero, bus.in_ready});
    end
    nChecks++;
    if (bus.sum !== 32'h0) begin
      nFails++;
      $display("[TB] FAIL reset_sum: got %h required 00000000", bus.sum);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single();
    int waitCycles;
    for (int i = 0; i < NVEC; i++) begin
      bus.in_valid = 1'b1;
      bus.a        = vecs[i].a;
      bus.b        = vecs[i].b;
      bus.cin      = vecs[i].cin;
      #1;
      nChecks++;
      if (bus.in_ready !== 1'b1) begin
        nFails++;
        $display("[TB] FAIL single_in_ready[%0d]: got %b required 1", i, bus.in_ready);
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
      waitCycles = 0;
      while (bus.out_valid !== 1'b1 && waitCycles < MAX_WAIT) begin
        @(negedge clk);
        waitCycles++;
      end
      nChecks++;
      if (waitCycles != NB - 1) begin
        nFails++;
        $display("[TB] FAIL single_latency[%0d]: got %0d required %0d", i, waitCycles, NB - 1);
      end
      nChecks++;
      if (bus.sum !== vecs[i].s) begin
        nFails++;
        $display("[TB] FAIL single_sum[%0d]: got %h required %h", i, bus.sum, vecs[i].s);
      end
      nChecks++;
      if ({bus.cout, bus.ovf, bus.zero} !== {vecs[i].c, vecs[i].o, vecs[i].z}) begin
        nFails++;
        $display("[TB] FAIL single_flags[%0d]: got c/o/z=%b required %b", i,
                 {bus.cout, bus.ovf, bus.zero}, {vecs[i].c, vecs[i].o, vecs[i].z});
      end
      @(negedge clk);
      nChecks++;
      if (bus.out_valid !== 1'b0) begin
        nFails++;
        $display("[TB] FAIL single_alone[%0d]: got out_valid=%b required 0", i, bus.out_valid);
      end
    end
  endtask

  task automatic test_back_to_back();
    int outIdx;
    outIdx = 0;
    bus.out_ready = 1'b1;
    for (int c = 0; c < NVEC + NB + 4; c++) begin
      if (bus.out_valid === 1'b1) begin
        nChecks++;
        if (c - NB != outIdx) begin
          nFails++;
          $display("[TB] FAIL b2b_slot: got beat %0d at cycle %0d required cycle %0d",
                   outIdx, c, outIdx + NB);
        end
        if (outIdx < NVEC) begin
          nChecks++;
          if (bus.sum !== vecs[outIdx].s ||
              {bus.cout, bus.ovf, bus.zero} !== {vecs[outIdx].c, vecs[outIdx].o, vecs[outIdx].z}) begin
            nFails++;
            $display("[TB] FAIL b2b_result[%0d]: got %h c/o/z=%b required %h c/o/z=%b", outIdx,
                     bus.sum, {bus.cout, bus.ovf, bus.zero},
                     vecs[outIdx].s, {vecs[outIdx].c, vecs[outIdx].o, vecs[outIdx].z});
          end
        end
        outIdx++;
      end
      if (c < NVEC) begin
        bus.in_valid = 1'b1;
        bus.a        = vecs[c].a;
        bus.b        = vecs[c].b;
        bus.cin      = vecs[c].cin;
      end else begin
        bus.in_valid = 1'b0;
      end
      @(negedge clk);
    end
    nChecks++;
    if (outIdx != NVEC) begin
      nFails++;
      $display("[TB] FAIL b2b_count: got %0d results required %0d", outIdx, NVEC);
    end
  endtask

  task automatic test_stall();
    logic [31:0] pat;
    logic [31:0] prevSum;
    logic        prevHold;
    int          inIdx;
    int          outIdx;
    pat      = 32'hB53C_96E1;
    prevSum  = '0;
    prevHold = 1'b0;
    inIdx    = 0;
    outIdx   = 0;
    for (int c = 0; c < 200 && outIdx < NVEC; c++) begin
      if (prevHold) begin
        nChecks++;
        if (bus.out_valid !== 1'b1 || bus.sum !== prevSum) begin
          nFails++;
          $display("[TB] FAIL stall_hold[%0d]: got v=%b sum=%h required v=1 sum=%h",
                   c, bus.out_valid, bus.sum, prevSum);
        end
      end
      bus.out_ready = pat[c % 32];
      bus.in_valid  = (inIdx < NVEC);
      if (inIdx < NVEC) begin
        bus.a   = vecs[inIdx].a;
        bus.b   = vecs[inIdx].b;
        bus.cin = vecs[inIdx].cin;
      end
      #1;
      nChecks++;
      if (bus.in_ready !== (bus.out_ready | ~bus.out_valid)) begin
        nFails++;
        $display("[TB] FAIL stall_in_ready[%0d]: got %b required %b",
                 c, bus.in_ready, bus.out_ready | ~bus.out_valid);
      end
      if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
        if (outIdx < NVEC) begin
          nChecks++;
          if (bus.sum !== vecs[outIdx].s ||
              {bus.cout, bus.ovf, bus.zero} !== {vecs[outIdx].c, vecs[outIdx].o, vecs[outIdx].z}) begin
            nFails++;
            $display("[TB] FAIL stall_result[%0d]: got %h c/o/z=%b required %h c/o/z=%b", outIdx,
                     bus.sum, {bus.cout, bus.ovf, bus.zero},
                     vecs[outIdx].s, {vecs[outIdx].c, vecs[outIdx].o, vecs[outIdx].z});
          end
        end
        outIdx++;
      end
      prevHold = (bus.out_valid === 1'b1) && (bus.out_ready === 1'b0);
      prevSum  = bus.sum;
      if (bus.in_valid === 1'b1 && bus.in_ready === 1'b1) begin
        inIdx++;
      end
      @(negedge clk);
    end
    nChecks++;
    if (outIdx != NVEC || inIdx != NVEC) begin
      nFails++;
      $display("[TB] FAIL stall_count: got in=%0d out=%0d required %0d each", inIdx, outIdx, NVEC);
    end
    driveIdle();
    for (int c = 0; c < NB + 2; c++) begin
      nChecks++;
      if (bus.out_valid !== 1'b0) begin
        nFails++;
        $display("[TB] FAIL stall_duplicate[%0d]: got out_valid=%b required 0", c, bus.out_valid);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_midflight();
    int waitCycles;
    for (int c = 0; c < NB; c++) begin
      bus.in_valid = 1'b1;
      bus.a        = vecs[5].a;
      bus.b        = vecs[5].b;
      bus.cin      = vecs[5].cin;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    nChecks++;
    if (bus.out_valid !== 1'b1 || bus.sum !== vecs[5].s) begin
      nFails++;
      $display("[TB] FAIL midrst_pre: got v=%b sum=%h required v=1 sum=%h",
               bus.out_valid, bus.sum, vecs[5].s);
    end
    #2;
    rst = 1'b1;
    #1;
    nChecks++;
    if ({bus.out_valid, bus.cout, bus.ovf, bus.zero} !== 4'b0000 || bus.sum !== 32'h0) begin
      nFails++;
      $display("[TB] FAIL midrst_async: got v/c/o/z=%b sum=%h required 0000 sum=00000000",
               {bus.out_valid, bus.cout, bus.ovf, bus.zero}, bus.sum);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    bus.in_valid = 1'b1;
    bus.a        = vecs[4].a;
    bus.b        = vecs[4].b;
    bus.cin      = vecs[4].cin;
    @(negedge clk);
    bus.in_valid = 1'b0;
    waitCycles = 0;
    while (bus.out_valid !== 1'b1 && waitCycles < MAX_WAIT) begin
      @(negedge clk);
      waitCycles++;
    end
    nChecks++;
    if (waitCycles != NB - 1 || bus.sum !== vecs[4].s) begin
      nFails++;
      $display("[TB] FAIL midrst_after: got latency=%0d sum=%h required latency=%0d sum=%h",
               waitCycles, bus.sum, NB - 1, vecs[4].s);
    end
    @(negedge clk);
    nChecks++;
    if (bus.out_valid !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL midrst_alone: got out_valid=%b required 0", bus.out_valid);
    end
  endtask

`ifdef CSEL_SUB_EN
  task automatic test_sub();
    vec_t subVecs [5];
    int   waitCycles;
    subVecs[0] = '{32'h0000_0005, 32'h0000_0007, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0};
    subVecs[1] = '{32'h0000_0007, 32'h0000_0005, 1'b0, 32'h0000_0002, 1'b1, 1'b0, 1'b0};
    subVecs[2] = '{32'h0000_0007, 32'h0000_0005, 1'b1, 32'h0000_0002, 1'b1, 1'b0, 1'b0};
    subVecs[3] = '{32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0};
    subVecs[4] = '{32'h0000_0005, 32'h0000_0005, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1;
      bus.sub      = 1'b1;
      bus.a        = subVecs[i].a;
      bus.b        = subVecs[i].b;
      bus.cin      = subVecs[i].cin;
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.sub      = 1'b0;
      waitCycles = 0;
      while (bus.out_valid !== 1'b1 && waitCycles < MAX_WAIT) begin
        @(negedge clk);
        waitCycles++;
      end
      nChecks++;
      if (waitCycles != NB - 1) begin
        nFails++;
        $display("[TB] FAIL sub_latency[%0d]: got %0d required %0d", i, waitCycles, NB - 1);
      end
      nChecks++;
      if (bus.sum !== subVecs[i].s ||
          {bus.cout, bus.ovf, bus.zero} !== {subVecs[i].c, subVecs[i].o, subVecs[i].z}) begin
        nFails++;
        $display("[TB] FAIL sub_result[%0d]: got %h c/o/z=%b required %h c/o/z=%b", i,
                 bus.sum, {bus.cout, bus.ovf, bus.zero},
                 subVecs[i].s, {subVecs[i].c, subVecs[i].o, subVecs[i].z});
      end
      @(negedge clk);
    end
  endtask
`endif

  initial begin
    vecs[0] = '{32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
    vecs[2] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b1};
    vecs[4] = '{32'h1234_5678, 32'h1111_1111, 1'b1, 32'h2345_678A, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b1};
    vecs[7] = '{32'h00FF_FFFF, 32'h0000_0001, 1'b0, 32'h0100_0000, 1'b0, 1'b0, 1'b0};

    driveIdle();
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_reset_midflight();
`ifdef CSEL_SUB_EN
    test_sub();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
